// File: rtl/reg_wb_ctrl_pkg.sv
// Shared types for the register-file write-back controller.
package reg_wb_ctrl_pkg;
   localparam int WB_AW = 5;
   localparam int WB_DW = 32;

   typedef enum logic [1:0] {IDLE, SETUP, STROBE} wb_state_e;

   typedef struct packed {
      logic [WB_AW-1:0] rd;
      logic [WB_DW-1:0] data;
   } wb_entry_t;
endpackage

// File: rtl/reg_wb_ctrl_if.sv
// Producer / register-file port bundle for reg_wb_ctrl; lookup ports only with WB_BYPASS_EN.
interface reg_wb_ctrl_if #(
   parameter int DEPTH = 4,
   parameter int AW    = 5,
   parameter int DW    = 32
);
   logic                     in_valid;
   logic                     in_ready;
   logic [AW-1:0]            in_rd;
   logic [DW-1:0]            in_data;
   logic [AW-1:0]            rgw1;
   logic [DW-1:0]            rgw1data;
   logic                     write;
   logic [$clog2(DEPTH):0]   level;
`ifdef WB_BYPASS_EN
   logic [AW-1:0]            lk1, lk2;
   logic                     lk1_hit, lk2_hit;
   logic [DW-1:0]            lk1_data, lk2_data;
`endif

   modport master (
      output in_valid, in_rd, in_data,
      input  in_ready, rgw1, rgw1data, write, level
`ifdef WB_BYPASS_EN
      , output lk1, lk2
      , input  lk1_hit, lk2_hit, lk1_data, lk2_data
`endif
   );

   modport slave (
      input  in_valid, in_rd, in_data,
      output in_ready, rgw1, rgw1data, write, level
`ifdef WB_BYPASS_EN
      , input  lk1, lk2
      , output lk1_hit, lk2_hit, lk1_data, lk2_data
`endif
   );
endinterface

// File: rtl/reg_wb_ctrl_wb_queue.sv
// Circular write-back FIFO; entries are also presented oldest-first for the bypass search.
module wb_queue
   import reg_wb_ctrl_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int PW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  wb_entry_t        din,
   input  logic             pop,
   output logic [PW:0]      level,
   output wb_entry_t        age_ent [DEPTH],
   output logic [DEPTH-1:0] age_vld
);
   wb_entry_t         mem_q [DEPTH];
   wb_entry_t         mem_d [DEPTH];
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [PW:0]       level_q, level_d;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (push) begin
         mem_d[wr_ptr_q] = din;
         wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
         2'b10:   level_d = level_q + (PW+1)'(1);
         2'b01:   level_d = level_q - (PW+1)'(1);
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   always_ff @(posedge clk) mem_q <= mem_d;

   // age index 0 is the head; higher index is newer
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         age_ent[i] = mem_q[rd_ptr_q + PW'(i)];
         age_vld[i] = ((PW+1)'(i) < level_q);
      end
   end

   assign level = level_q;
endmodule

// File: rtl/reg_wb_ctrl.sv
// Write-back controller: queues {rd,data} pairs and issues SETUP/STROBE writes to the register file.
// Optional bypass of queued / last-retired values with `define WB_BYPASS_EN.
module reg_wb_ctrl
   import reg_wb_ctrl_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int AW    = WB_AW,
   parameter int DW    = WB_DW
) (
   input logic         clk,
   input logic         reset,
   reg_wb_ctrl_if.slave bus
);
   localparam int PW = $clog2(DEPTH);

   wb_state_e        state_q, state_d;
   logic             write_q, write_d;
   logic [AW-1:0]    rgw1_q, rgw1_d;
   logic [DW-1:0]    rgw1data_q, rgw1data_d;
   logic             push, pop;
   wb_entry_t        din, next_head;
   logic [PW:0]      level;
   wb_entry_t        age_ent [DEPTH];
   logic [DEPTH-1:0] age_vld;

   assign bus.in_ready = !reset && (level < (PW+1)'(DEPTH));
   // index 0 completes the handshake but never enters the queue
   assign push = bus.in_valid && bus.in_ready && (bus.in_rd != '0);
   assign pop  = (state_q == STROBE);
   assign din  = '{rd: bus.in_rd, data: bus.in_data};

   wb_queue #(.DEPTH(DEPTH)) u_queue (
      .clk     (clk),
      .reset   (reset),
      .push    (push),
      .din     (din),
      .pop     (pop),
      .level   (level),
      .age_ent (age_ent),
      .age_vld (age_vld)
   );

   // entry the next SETUP will present; may still be arriving on the input
   always_comb begin
      if (state_q == STROBE)
         next_head = (level > (PW+1)'(1)) ? age_ent[1] : din;
      else
         next_head = (level != '0) ? age_ent[0] : din;
   end

   always_comb begin
      state_d    = state_q;
      rgw1_d     = rgw1_q;
      rgw1data_d = rgw1data_q;
      case (state_q)
         IDLE:    if (level != '0 || push) state_d = SETUP;
         SETUP:   state_d = STROBE;
         STROBE:  state_d = (level > (PW+1)'(1) || push) ? SETUP : IDLE;
         default: state_d = IDLE;
      endcase
      if (state_d == SETUP) begin
         rgw1_d     = next_head.rd;
         rgw1data_d = next_head.data;
      end
      write_d = (state_d == STROBE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         write_q    <= 1'b0;
         rgw1_q     <= '0;
         rgw1data_q <= '0;
      end else begin
         state_q    <= state_d;
         write_q    <= write_d;
         rgw1_q     <= rgw1_d;
         rgw1data_q <= rgw1data_d;
      end
   end

   assign bus.write    = write_q;
   assign bus.rgw1     = rgw1_q;
   assign bus.rgw1data = rgw1data_q;
   assign bus.level    = level;

`ifdef WB_BYPASS_EN
   logic          lr_vld_q, lr_vld_d;
   logic [AW-1:0] lr_rd_q, lr_rd_d;
   logic [DW-1:0] lr_data_q, lr_data_d;

   always_comb begin
      lr_vld_d  = lr_vld_q;
      lr_rd_d   = lr_rd_q;
      lr_data_d = lr_data_q;
      if (pop) begin
         lr_vld_d  = 1'b1;
         lr_rd_d   = age_ent[0].rd;
         lr_data_d = age_ent[0].data;
      end
      if (push && bus.in_rd == lr_rd_d) lr_vld_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         lr_vld_q  <= 1'b0;
         lr_rd_q   <= '0;
         lr_data_q <= '0;
      end else begin
         lr_vld_q  <= lr_vld_d;
         lr_rd_q   <= lr_rd_d;
         lr_data_q <= lr_data_d;
      end
   end

   // {hit, data}; later (newer) queue matches override older ones and the last-retired value
   function automatic logic [DW:0] lookup(input logic [AW-1:0] idx);
      logic          hit;
      logic [DW-1:0] d;
      hit = 1'b0;
      d   = '0;
      if (idx != '0) begin
         if (lr_vld_q && lr_rd_q == idx) begin
            hit = 1'b1;
            d   = lr_data_q;
         end
         for (int i = 0; i < DEPTH; i++) begin
            if (age_vld[i] && age_ent[i].rd == idx) begin
               hit = 1'b1;
               d   = age_ent[i].data;
            end
         end
      end
      return {hit, d};
   endfunction

   always_comb begin
      {bus.lk1_hit, bus.lk1_data} = lookup(bus.lk1);
      {bus.lk2_hit, bus.lk2_data} = lookup(bus.lk2);
   end
`else
   logic unused_age;
   always_comb begin
      unused_age = ^age_vld;
      for (int i = 0; i < DEPTH; i++) unused_age = unused_age ^ (^age_ent[i]);
   end
`endif
endmodule
